sap1_sequencer: RTL and testbench
=================================

SAP1_SEQUENCER -- requirements
Module: sap1_sequencer

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 4'h0, program counter value loaded on reset.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level-sampled run request; honoured only in IDLE.
REQ-006 ram_rdata  input  8  RAM read data, combinational from ram_addr while ram_ce=1.
REQ-007 ram_ce  output  1  RAM chip enable.
REQ-008 ram_we  output  1  RAM write enable; RAM writes on the clk edge when ram_ce=1 and ram_we=1.
REQ-009 ram_addr  output  4  RAM address.
REQ-010 ram_wdata  output  8  RAM write data.
REQ-011 out_port  output  8  registered output-register value.
REQ-012 out_valid  output  1  one-cycle pulse each time out_port is loaded.
REQ-013 carry  output  1  carry/borrow from the last ADD or SUB.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, DECODE, EXECUTE and HALT. Transitions: IDLE->FETCH when start=1; FETCH->DECODE; DECODE->EXECUTE; EXECUTE->FETCH, except HLT, which goes EXECUTE->HALT.
REQ-016 FETCH SHALL drive ram_addr=PC, ram_ce=1, ram_we=0, then on the edge load IR<=ram_rdata and PC<=PC+1 modulo 16 (15 wraps to 0).
REQ-017 DECODE SHALL hold ram_ce=0 and ram_we=0, and change no architectural register.
REQ-018 Opcode IR[7:4], operand IR[3:0]: 0000 LDA, 0001 SUB, 0010 ADD, 0011 STA, 0100 JMP, 1110 OUT, 1111 HLT; every other opcode is a NOP.
REQ-019 In EXECUTE, LDA/ADD/SUB SHALL drive ram_addr=IR[3:0], ram_ce=1, ram_we=0 and update ACC on the edge.
REQ-020 LDA: ACC<=ram_rdata; carry unchanged.
REQ-021 ADD: {carry,ACC}<=ACC+ram_rdata, as a 9-bit sum.
REQ-022 SUB: ACC<=(ACC-ram_rdata) mod 256; carry<=1 when ram_rdata>ACC (borrow).
REQ-023 STA SHALL drive ram_addr=IR[3:0], ram_ce=1, ram_we=1, ram_wdata=ACC for exactly one cycle.
REQ-024 JMP SHALL load PC<=IR[3:0], overriding the FETCH increment.
REQ-025 OUT SHALL load out_port<=ACC and assert out_valid in the following cycle only.
REQ-026 Every instruction SHALL take exactly 3 cycles (FETCH, DECODE, EXECUTE).
REQ-027 ram_ce and ram_we SHALL be 0 in IDLE, DECODE, HALT, and in EXECUTE for JMP/OUT/HLT/NOP; ram_wdata SHALL equal ACC at all times.
REQ-028 HALT SHALL be sticky: start is ignored and only rst leaves HALT.
REQ-029 start asserted outside IDLE SHALL have no effect.

Reset
REQ-030 While rst=1, regardless of state: FSM=IDLE, PC=RESET_PC, IR=0, ACC=0, carry=0, out_port=0, out_valid=0, halted=0, ram_ce=0, ram_we=0.
REQ-031 When rst asserts mid-STA, ram_we SHALL drop in the same cycle, with no clock edge required.
REQ-032 After rst deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-033 Program load:
- RAM: 0:05, 1:26, 2:E0, 3:37, 4:F0, 5:04, 6:02.
- start pulse -> out_port=06 with out_valid pulse.
- mem[7]=06.
- halted=1 exactly 15 cycles after FETCH is first entered.
- Afterwards ram_ce stays 0.
REQ-034 ADD overflow: ACC=F0 (LDA), ADD operand 20 -> ACC=10, carry=1. A following LDA leaves carry=1.
REQ-035 SUB borrow: ACC=03, SUB operand 05 -> ACC=FE, carry=1. Then SUB operand 01 -> ACC=FD, carry=0.
REQ-036 Wrap and jump:
- NOP at addresses 0-15, no HLT -> PC sequence 0..15 then 0.
- JMP 9 at address 2 -> next FETCH address 9.
REQ-037 Reset mid-operation:
- rst during EXECUTE of STA -> ram_we=0 immediately; target address unchanged.
- All outputs take their reset values.
- start in HALT before rst has no effect.

Source files
------------

// File: rtl/sap1_sequencer.sv
// SAP-1 style control sequencer: 3-cycle FETCH/DECODE/EXECUTE loop driving an
// external 16x8 RAM, with accumulator, carry flag and output register.
module sap1_sequencer #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ram_rdata,
    output logic       ram_ce,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic [7:0] out_port,
    output logic       out_valid,
    output logic       carry,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] out_port_q, out_port_d;
    logic       carry_q, carry_d;
    logic       out_valid_q, out_valid_d;
    logic       halted_q, halted_d;
    logic       ram_ce_q, ram_ce_d;
    logic       ram_we_q, ram_we_d;
    logic [3:0] ram_addr_q, ram_addr_d;

    logic [3:0] opcode;
    logic [3:0] operand;
    logic [8:0] sum;
    logic       is_mem_op;

    assign opcode    = ir_q[7:4];
    assign operand   = ir_q[3:0];
    assign sum       = {1'b0, acc_q} + {1'b0, ram_rdata};
    assign is_mem_op = (opcode == OP_LDA) || (opcode == OP_SUB) ||
                       (opcode == OP_ADD) || (opcode == OP_STA);

    assign ram_ce    = ram_ce_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = acc_q;
    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;
    assign carry     = carry_q;
    assign halted    = halted_q;

    // RAM strobes are registered: they are computed for the state being entered,
    // so the async reset clears them without waiting for a clock edge.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        acc_d       = acc_q;
        out_port_d  = out_port_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        halted_d    = halted_q;
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = ram_rdata;
                pc_d    = pc_q + 4'd1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
                if (is_mem_op) begin
                    ram_ce_d   = 1'b1;
                    ram_we_d   = (opcode == OP_STA);
                    ram_addr_d = operand;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDA: acc_d = ram_rdata;
                    OP_ADD: {carry_d, acc_d} = sum;
                    OP_SUB: begin
                        acc_d   = acc_q - ram_rdata;
                        carry_d = (ram_rdata > acc_q);
                    end
                    OP_JMP: pc_d = operand;
                    OP_OUT: begin
                        out_port_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OP_HLT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_FETCH) begin
            ram_ce_d   = 1'b1;
            ram_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 8'h00;
            acc_q       <= 8'h00;
            out_port_q  <= 8'h00;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            ram_ce_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 4'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            acc_q       <= acc_d;
            out_port_q  <= out_port_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            ram_ce_q    <= ram_ce_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
        end
    end

endmodule

// File: tb/tb_sap1_sequencer.sv
// Scoreboard bench for sap1_sequencer: directed programs push expected RAM
// reads, RAM writes and OUT results; a negedge monitor pops and compares them.
module tb_sap1_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] ram_rdata;
    logic       ram_ce;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] out_port;
    logic       out_valid;
    logic       carry;
    logic       halted;

    logic [7:0] memArr [16];
    logic       loadEn;
    logic [3:0] loadAddr;
    logic [7:0] loadData;

    logic [3:0] rdQ [$];
    logic [11:0] wrQ [$];
    logic [8:0] outQ [$];

    int checks = 0;
    int errors = 0;

    sap1_sequencer #(.RESET_PC(4'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram_rdata (ram_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .out_port  (out_port),
        .out_valid (out_valid),
        .carry     (carry),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: bench load port has priority over DUT writes
    always @(posedge clk) begin
        if (loadEn) memArr[loadAddr] <= loadData;
        else if (ram_ce && ram_we) memArr[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ram_ce ? memArr[ram_addr] : 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: DUT presented an event with nothing expected", name);
    endtask

    // Monitor: compare every RAM access and every OUT pulse against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_ce && ram_we) begin
                if (wrQ.size() == 0) unexpected("ram write");
                else checkOutput("ram write addr/data", {20'h0, ram_addr, ram_wdata}, {20'h0, wrQ.pop_front()});
            end else if (ram_ce) begin
                if (rdQ.size() == 0) unexpected("ram read");
                else checkOutput("ram read addr", {28'h0, ram_addr}, {28'h0, rdQ.pop_front()});
            end
            if (out_valid) begin
                if (outQ.size() == 0) unexpected("out pulse");
                else checkOutput("out carry/port", {23'h0, carry, out_port}, {23'h0, outQ.pop_front()});
            end
        end
    end

    task automatic loadWord(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        loadAddr = a;
        loadData = d;
        loadEn   = 1'b1;
        @(negedge clk);
        loadEn   = 1'b0;
    endtask

    task automatic resetAndFill(input logic [7:0] fill);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) loadWord(i[3:0], fill);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitHalt(output int n);
        n = 0;
        while (!halted && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("halt reached", {31'h0, halted}, 32'h1);
    endtask

    task automatic waitDrained(input string name);
        int budget = 0;
        while ((rdQ.size() + wrQ.size() + outQ.size()) != 0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        checkOutput(name, rdQ.size() + wrQ.size() + outQ.size(), 0);
    endtask

    initial begin
        int n;
        logic ceSeen;
        rst      = 1'b1;
        start    = 1'b0;
        loadEn   = 1'b0;
        loadAddr = 4'h0;
        loadData = 8'h00;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", {20'h0, ram_ce, ram_we, out_valid, carry, out_port}, 32'h0);
        checkOutput("reset halted", {31'h0, halted}, 32'h0);

        // Program load: LDA 5, ADD 6, OUT, STA 7, HLT
        resetAndFill(8'h00);
        loadWord(4'h0, 8'h05); loadWord(4'h1, 8'h26); loadWord(4'h2, 8'hE0);
        loadWord(4'h3, 8'h37); loadWord(4'h4, 8'hF0); loadWord(4'h5, 8'h04);
        loadWord(4'h6, 8'h02);
        releaseReset();
        checkOutput("idle no access", {31'h0, ram_ce}, 32'h0);
        rdQ = '{4'h0, 4'h5, 4'h1, 4'h6, 4'h2, 4'h3, 4'h4};
        wrQ.push_back({4'h7, 8'h06});
        outQ.push_back({1'b0, 8'h06});
        applyStimulus();
        waitHalt(n);
        checkOutput("halt latency", n, 15);
        checkOutput("mem7 stored", {24'h0, memArr[7]}, 32'h06);
        waitDrained("prog1 drained");
        // start while halted must be ignored
        ceSeen = 1'b0;
        start  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ram_ce || !halted) ceSeen = 1'b1;
        end
        start = 1'b0;
        checkOutput("halt sticky, no access", {31'h0, ceSeen}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("reset from halt", {19'h0, halted, ram_ce, ram_we, out_valid, carry, out_port}, 32'h0);

        // ADD overflow: F0 + 20 -> 10 carry 1, then LDA keeps carry
        resetAndFill(8'h00);
        loadWord(4'h0, 8'h08); loadWord(4'h1, 8'h29); loadWord(4'h2, 8'hE0);
        loadWord(4'h3, 8'h0A); loadWord(4'h4, 8'hE0); loadWord(4'h5, 8'hF0);
        loadWord(4'h8, 8'hF0); loadWord(4'h9, 8'h20); loadWord(4'hA, 8'h55);
        releaseReset();
        rdQ = '{4'h0, 4'h8, 4'h1, 4'h9, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5};
        outQ = '{{1'b1, 8'h10}, {1'b1, 8'h55}};
        applyStimulus();
        waitHalt(n);
        waitDrained("add drained");
        checkOutput("add final carry", {31'h0, carry}, 32'h1);

        // SUB borrow: 03 - 05 -> FE c1, FE - 01 -> FD c0
        resetAndFill(8'h00);
        loadWord(4'h0, 8'h08); loadWord(4'h1, 8'h19); loadWord(4'h2, 8'hE0);
        loadWord(4'h3, 8'h1A); loadWord(4'h4, 8'hE0); loadWord(4'h5, 8'hF0);
        loadWord(4'h8, 8'h03); loadWord(4'h9, 8'h05); loadWord(4'hA, 8'h01);
        releaseReset();
        rdQ = '{4'h0, 4'h8, 4'h1, 4'h9, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5};
        outQ = '{{1'b1, 8'hFE}, {1'b0, 8'hFD}};
        applyStimulus();
        waitHalt(n);
        waitDrained("sub drained");

        // PC wrap: all NOPs, fetch addresses 0..15 then 0, 1
        resetAndFill(8'h50);
        releaseReset();
        for (int i = 0; i < 18; i++) rdQ.push_back(i[3:0]);
        applyStimulus();
        waitDrained("wrap drained");
        checkOutput("wrap not halted", {31'h0, halted}, 32'h0);
        rst = 1'b1;

        // JMP 9 at address 2
        resetAndFill(8'h00);
        loadWord(4'h0, 8'h50); loadWord(4'h1, 8'h50); loadWord(4'h2, 8'h49);
        loadWord(4'h9, 8'hF0);
        releaseReset();
        rdQ = '{4'h0, 4'h1, 4'h2, 4'h9};
        applyStimulus();
        waitHalt(n);
        waitDrained("jmp drained");

        // Reset during STA execute: ram_we drops at once, target untouched
        resetAndFill(8'h00);
        loadWord(4'h0, 8'h0F); loadWord(4'h1, 8'h3E); loadWord(4'h2, 8'hF0);
        loadWord(4'hE, 8'h11); loadWord(4'hF, 8'h77);
        releaseReset();
        rdQ = '{4'h0, 4'hF, 4'h1};
        wrQ.push_back({4'hE, 8'h77});
        applyStimulus();
        n = 0;
        while (!ram_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sta strobe seen", {31'h0, ram_we}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("sta abort we/ce", {30'h0, ram_we, ram_ce}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("sta target unchanged", {24'h0, memArr[14]}, 32'h11);
        checkOutput("reset mid-op outputs", {19'h0, halted, ram_ce, ram_we, out_valid, carry, out_port}, 32'h0);
        checkOutput("sta queues", rdQ.size() + wrQ.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        ceSeen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ram_ce || halted) ceSeen = 1'b1;
        end
        checkOutput("idle after reset", {31'h0, ceSeen}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
